// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port (WE3/A3/WD3) among
// ALU (0), memory load (1) and debug/loader (2); writes to R15 are discarded and counted.
module regfile_write_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       req_valid,
  output logic [2:0]       req_ready,
  input  logic [3:0]       req_addr0,
  input  logic [3:0]       req_addr1,
  input  logic [3:0]       req_addr2,
  input  logic [N-1:0]     req_data0,
  input  logic [N-1:0]     req_data1,
  input  logic [N-1:0]     req_data2,
  output logic             we_o,
  output logic [3:0]       a3_o,
  output logic [N-1:0]     wd3_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       dbg_ptr
);

  // Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i];
  // it holds addr/data stable while valid && !ready and may drop valid before the grant.

  localparam logic [3:0]       PC_REG  = 4'd15;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]   ptr;
  logic [1:0]   ptr_next;
  logic         xfer;
  logic [3:0]   sel_addr;
  logic [N-1:0] sel_data;
  logic         sel_is_pc;

  assign dbg_ptr = ptr;

  // First valid requester at or after ptr, wrapping modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(p) + k) % 3;
      if (!found && v[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pointer state register.
  always_ff @(posedge clk) begin
    if (rst) ptr <= 2'd0;
    else     ptr <= ptr_next;
  end

  // Pointer next-state: advance past whoever was granted, hold otherwise.
  always_comb begin
    ptr_next = ptr;
    if (req_ready[0])      ptr_next = 2'd1;
    else if (req_ready[1]) ptr_next = 2'd2;
    else if (req_ready[2]) ptr_next = 2'd0;
  end

  // Grant output: suppressed entirely during reset or stall.
  always_comb begin
    req_ready = 3'b000;
    if (!rst && !stall) req_ready = rr_pick(req_valid, ptr);
  end

  assign xfer = |req_ready;

  always_comb begin
    sel_addr = 4'd0;
    sel_data = '0;
    if (req_ready[0]) begin
      sel_addr = req_addr0;
      sel_data = req_data0;
    end else if (req_ready[1]) begin
      sel_addr = req_addr1;
      sel_data = req_data1;
    end else if (req_ready[2]) begin
      sel_addr = req_addr2;
      sel_data = req_data2;
    end
  end

  assign sel_is_pc = (sel_addr == PC_REG);

  // Registered write port; R15 is fed from the PC path so such writes become drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_o     <= 1'b0;
      a3_o     <= 4'd0;
      wd3_o    <= '0;
      drop_o   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      we_o   <= xfer && !sel_is_pc;
      drop_o <= xfer && sel_is_pc;
      if (xfer && !sel_is_pc) begin
        a3_o  <= sel_addr;
        wd3_o <= sel_data;
      end
      if (xfer && sel_is_pc && drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed grants, writes and drop counts.
module tb_regfile_write_arbiter;

  localparam int N     = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             stall;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [3:0]       req_addr0, req_addr1, req_addr2;
  logic [N-1:0]     req_data0, req_data1, req_data2;
  logic             we_o;
  logic [3:0]       a3_o;
  logic [N-1:0]     wd3_o;
  logic             drop_o;
  logic [CNT_W-1:0] drop_cnt;
  logic [1:0]       dbg_ptr;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] exp_q[$];

  regfile_write_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
    .we_o(we_o), .a3_o(a3_o), .wd3_o(wd3_o),
    .drop_o(drop_o), .drop_cnt(drop_cnt), .dbg_ptr(dbg_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]   addrs[3];
    logic [N-1:0] datas[3];
    logic [35:0]  exp_w;
    int           g;
    int           exp_cnt;

    rst = 1'b1; stall = 1'b0; req_valid = 3'b000;
    req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
    req_data0 = '0; req_data1 = '0; req_data2 = '0;
    tick();
    req_valid = 3'b111;
    settle();
    check("rst_ready", req_ready, 3'b000);
    tick();
    check("rst_we", we_o, 0);
    check("rst_a3", a3_o, 0);
    check("rst_wd3", wd3_o, 0);
    check("rst_drop", drop_o, 0);
    check("rst_cnt", drop_cnt, 0);
    check("rst_ptr", dbg_ptr, 0);
    req_valid = 3'b000;
    rst = 1'b0;

    // 1: single requester 1
    req_valid = 3'b010; req_addr1 = 4'd3; req_data1 = 32'hDEADBEEF;
    settle();
    check("t1_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    check("t1_we", we_o, 1);
    check("t1_a3", a3_o, 3);
    check("t1_wd3", wd3_o, 32'hDEADBEEF);
    settle();
    check("t1_idle_ready", req_ready, 3'b000);
    tick();
    check("t1_we_low", we_o, 0);
    check("t1_a3_hold", a3_o, 3);

    // 2: all three valid for 6 cycles from ptr=0
    do_reset();
    addrs[0] = 4'd1; addrs[1] = 4'd2; addrs[2] = 4'd4;
    datas[0] = 32'hA0A0_0001; datas[1] = 32'hB1B1_0002; datas[2] = 32'hC2C2_0004;
    req_addr0 = addrs[0]; req_addr1 = addrs[1]; req_addr2 = addrs[2];
    req_data0 = datas[0]; req_data1 = datas[1]; req_data2 = datas[2];
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      settle();
      check("t2_ready", req_ready, 3'b001 << g);
      exp_q.push_back({addrs[g], datas[g]});
      tick();
      exp_w = exp_q.pop_front();
      check("t2_we", we_o, 1);
      check("t2_a3", a3_o, exp_w[35:32]);
      check("t2_wd3", wd3_o, exp_w[31:0]);
    end
    req_valid = 3'b000;
    check("t2_ptr", dbg_ptr, 0);

    // 3: R15 write from requester 0 is accepted and dropped
    req_valid = 3'b001; req_addr0 = 4'd15; req_data0 = 32'h12345678;
    settle();
    check("t3_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("t3_we", we_o, 0);
    check("t3_drop", drop_o, 1);
    check("t3_cnt", drop_cnt, 1);
    check("t3_a3_hold", a3_o, 4);
    check("t3_wd3_hold", wd3_o, 32'hC2C2_0004);
    tick();
    check("t3_drop_pulse", drop_o, 0);
    check("t3_cnt_hold", drop_cnt, 1);

    // 4: stall blocks all grants, ptr (now 1) unchanged
    req_addr0 = 4'd1;
    stall = 1'b1; req_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t4_stall_ready", req_ready, 3'b000);
      tick();
      check("t4_stall_we", we_o, 0);
    end
    stall = 1'b0;
    settle();
    check("t4_release_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    check("t4_we", we_o, 1);
    check("t4_a3", a3_o, 2);

    // 5: 300 consecutive R15 writes saturate the counter
    exp_cnt = 1;
    req_valid = 3'b001; req_addr0 = 4'd15;
    for (int c = 0; c < 300; c++) begin
      settle();
      check("t5_ready", req_ready, 3'b001);
      tick();
      if (exp_cnt < 255) exp_cnt++;
      check("t5_drop", drop_o, 1);
      check("t5_we", we_o, 0);
      check("t5_cnt", drop_cnt, exp_cnt);
    end
    req_valid = 3'b000;
    tick();
    check("t5_cnt_sat", drop_cnt, 255);

    // 6: reset coincident with a request; no transfer, then normal grant
    req_valid = 3'b001; req_addr0 = 4'd5; req_data0 = 32'h0BAD_F00D;
    rst = 1'b1;
    settle();
    check("t6_rst_ready", req_ready, 3'b000);
    tick();
    rst = 1'b0;
    check("t6_rst_we", we_o, 0);
    check("t6_rst_a3", a3_o, 0);
    check("t6_rst_cnt", drop_cnt, 0);
    settle();
    check("t6_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("t6_we", we_o, 1);
    check("t6_a3", a3_o, 5);
    check("t6_wd3", wd3_o, 32'h0BAD_F00D);
    tick();
    check("t6_we_low", we_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
